// File: rtl/ntp_client_pkg.sv
// Shared definitions for the NTP timestamp engine: register word indices,
// CTRL/STATUS bit positions, reset increment and the timestamp struct.
package ntp_client_pkg;

  // Register map as 32-bit word indices (byte offset >> 2).
  localparam logic [3:0] RegCtrl    = 4'h0;
  localparam logic [3:0] RegInc     = 4'h1;
  localparam logic [3:0] RegSetSec  = 4'h2;
  localparam logic [3:0] RegSetFrac = 4'h3;
  localparam logic [3:0] RegNowSec  = 4'h4;
  localparam logic [3:0] RegNowFrac = 4'h5;
  localparam logic [3:0] RegStatus  = 4'h6;
  // Capture channel n occupies words RegCapBase + 2n (sec) and + 2n + 1 (frac).
  localparam int unsigned RegCapBase = 8;

  localparam int unsigned CtrlRun       = 0;
  localparam int unsigned CtrlLoad      = 1;
  localparam int unsigned CtrlIrqEn     = 2;
  localparam int unsigned StatusOvrBase = 8;

  // 2^40 / 100e6 ~= 10995 (units of 2^-40 s per clock).
  localparam int unsigned IncResetDefault = 10995;

  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] frac;
  } ntp_ts_t;

  typedef enum logic {StWrIdle, StWrResp} wr_state_e;
  typedef enum logic {StRdIdle, StRdResp} rd_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ntp_timestamp_axil_if.sv
// AXI4-Lite bus bundle for the NTP timestamp engine.
// master: drives aw/w/ar channels and bready/rready; slave: drives the rest.
interface ntp_timestamp_axil_if #(
  parameter int unsigned AddrWidth = 6
);
  logic [AddrWidth-1:0] awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [AddrWidth-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ntp_ts_counter.sv
// Free-running 32.32 NTP time: 40-bit fraction accumulator plus 32-bit seconds.
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   run_i                   add inc_i to the accumulator every cycle
//   load_i                  load load_sec_i / {load_frac_i, 8'h00}; overrides run_i
//   inc_i                   per-clock increment in units of 2^-40 s
//   ts_o                    live {sec, top 32 bits of fraction}
//   pps_o                   high in the cycle the rolled-over seconds value is shown
module ntp_ts_counter
  import ntp_client_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        load_i,
  input  logic [31:0] load_sec_i,
  input  logic [31:0] load_frac_i,
  input  logic [31:0] inc_i,
  output ntp_ts_t     ts_o,
  output logic        pps_o
);

  logic [39:0] frac_q, frac_d;
  logic [31:0] sec_q, sec_d;
  logic        pps_q, pps_d;
  logic [40:0] sum;

  always_comb begin
    sum    = {1'b0, frac_q} + {9'd0, inc_i};
    frac_d = frac_q;
    sec_d  = sec_q;
    pps_d  = 1'b0;
    if (load_i) begin
      sec_d  = load_sec_i;
      frac_d = {load_frac_i, 8'h00};
    end else if (run_i) begin
      frac_d = sum[39:0];
      if (sum[40]) begin
        // Era rollover 0xFFFFFFFF -> 0 falls out of the natural wrap.
        sec_d = sec_q + 32'd1;
        pps_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frac_q <= '0;
      sec_q  <= '0;
      pps_q  <= 1'b0;
    end else begin
      frac_q <= frac_d;
      sec_q  <= sec_d;
      pps_q  <= pps_d;
    end
  end

  assign ts_o  = '{sec: sec_q, frac: frac_q[39:8]};
  assign pps_o = pps_q;

endmodule

// File: rtl/ntp_timestamp_axil.sv
// AXI4-Lite controlled NTP timestamp engine: programmable-rate 32.32 clock,
// atomic NOW read, and NUM_CAP event capture registers with valid/overrun flags.
// Ports:
//   s00_axi_aclk, s00_axi_aresetn   clock, synchronous active-low reset
//   s00_axi                         AXI4-Lite slave (interface, slave modport)
//   cap_i                           single-cycle capture pulses
//   ntp_sec_o, ntp_frac_o           live time
//   pps_o                           seconds rollover pulse
//   irq_o                           capture interrupt (level)
// Build option: define NTP_CLIENT_IRQ_EN to store CTRL[2] and drive irq_o;
// otherwise irq_o is tied low and CTRL[2] reads 0.
module ntp_timestamp_axil
  import ntp_client_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_CAP            = 2,
  parameter int unsigned INC_RESET          = IncResetDefault
) (
  input  logic                s00_axi_aclk,
  input  logic                s00_axi_aresetn,
  ntp_timestamp_axil_if.slave s00_axi,
  input  logic [NUM_CAP-1:0]  cap_i,
  output logic [31:0]         ntp_sec_o,
  output logic [31:0]         ntp_frac_o,
  output logic                pps_o,
  output logic                irq_o
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic      wr_en, rd_en;

  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr, raddr;
  logic [3:0]                    w_idx, r_idx;
  logic                          unused_addr;

  logic                          run_q, run_d, load_q, load_d, irq_en_q;
  logic [31:0]                   inc_q, inc_d, set_sec_q, set_sec_d;
  logic [31:0]                   set_frac_q, set_frac_d, shadow_q, shadow_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic [NUM_CAP-1:0]            cap_valid_q, cap_valid_d, overrun_q, overrun_d;
  logic [NUM_CAP-1:0]            w1c_valid, w1c_ovr;
  ntp_ts_t                       cap_q [NUM_CAP];
  ntp_ts_t                       cap_d [NUM_CAP];
  ntp_ts_t                       ts;

  assign waddr       = s00_axi.awaddr;
  assign raddr       = s00_axi.araddr;
  assign w_idx       = waddr[5:2];
  assign r_idx       = raddr[5:2];
  assign unused_addr = ^{waddr[1:0], raddr[1:0]};

  // Bus FSM: state registers.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      wr_state_q <= StWrIdle;
      rd_state_q <= StRdIdle;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Bus FSM: next state.
  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    case (wr_state_q)
      StWrIdle: if (s00_axi.awvalid && s00_axi.wvalid) wr_state_d = StWrResp;
      StWrResp: if (s00_axi.bready) wr_state_d = StWrIdle;
      default:  wr_state_d = StWrIdle;
    endcase
    case (rd_state_q)
      StRdIdle: if (s00_axi.arvalid) rd_state_d = StRdResp;
      StRdResp: if (s00_axi.rready) rd_state_d = StRdIdle;
      default:  rd_state_d = StRdIdle;
    endcase
  end

  // Bus FSM: outputs. AW and W are only taken together.
  always_comb begin
    wr_en           = (wr_state_q == StWrIdle) && s00_axi.awvalid && s00_axi.wvalid;
    rd_en           = (rd_state_q == StRdIdle) && s00_axi.arvalid;
    s00_axi.awready = wr_en;
    s00_axi.wready  = wr_en;
    s00_axi.bvalid  = (wr_state_q == StWrResp);
    s00_axi.bresp   = 2'b00;
    s00_axi.arready = rd_en;
    s00_axi.rvalid  = (rd_state_q == StRdResp);
    s00_axi.rresp   = 2'b00;
    s00_axi.rdata   = rdata_q;
  end

  // Register writes and capture bank.
  always_comb begin
    run_d      = run_q;
    load_d     = 1'b0;
    inc_d      = inc_q;
    set_sec_d  = set_sec_q;
    set_frac_d = set_frac_q;
    w1c_valid  = '0;
    w1c_ovr    = '0;
    if (wr_en) begin
      case (w_idx)
        RegCtrl: begin
          if (s00_axi.wstrb[0]) begin
            run_d  = s00_axi.wdata[CtrlRun];
            load_d = s00_axi.wdata[CtrlLoad];
          end
        end
        RegInc:     inc_d      = apply_strb(inc_q, s00_axi.wdata, s00_axi.wstrb);
        RegSetSec:  set_sec_d  = apply_strb(set_sec_q, s00_axi.wdata, s00_axi.wstrb);
        RegSetFrac: set_frac_d = apply_strb(set_frac_q, s00_axi.wdata, s00_axi.wstrb);
        RegStatus: begin
          w1c_valid = s00_axi.wdata[NUM_CAP-1:0] & {NUM_CAP{s00_axi.wstrb[0]}};
          w1c_ovr   = s00_axi.wdata[StatusOvrBase +: NUM_CAP] & {NUM_CAP{s00_axi.wstrb[1]}};
        end
        default: ;
      endcase
    end

    cap_d       = cap_q;
    cap_valid_d = cap_valid_q & ~w1c_valid;
    overrun_d   = overrun_q & ~w1c_ovr;
    for (int unsigned n = 0; n < NUM_CAP; n++) begin
      if (cap_i[n]) begin
        // A clear landing with a capture frees the slot, so the capture is taken.
        if (!cap_valid_q[n] || w1c_valid[n]) begin
          cap_d[n]       = ts;
          cap_valid_d[n] = 1'b1;
        end else begin
          overrun_d[n] = 1'b1;
        end
      end
    end
  end

  // Read mux; a NOW_SEC read snapshots the fraction for the following NOW_FRAC read.
  always_comb begin
    rd_mux = '0;
    case (r_idx)
      RegCtrl: begin
        rd_mux[CtrlRun]   = run_q;
        rd_mux[CtrlIrqEn] = irq_en_q;
      end
      RegInc:     rd_mux = inc_q;
      RegSetSec:  rd_mux = set_sec_q;
      RegSetFrac: rd_mux = set_frac_q;
      RegNowSec:  rd_mux = ts.sec;
      RegNowFrac: rd_mux = shadow_q;
      RegStatus: begin
        rd_mux[NUM_CAP-1:0]                = cap_valid_q;
        rd_mux[StatusOvrBase +: NUM_CAP]   = overrun_q;
      end
      default: begin
        for (int unsigned n = 0; n < NUM_CAP; n++) begin
          if (r_idx == 4'(RegCapBase + 2 * n))     rd_mux = cap_q[n].sec;
          if (r_idx == 4'(RegCapBase + 2 * n + 1)) rd_mux = cap_q[n].frac;
        end
      end
    endcase

    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    if (rd_en) begin
      rdata_d = rd_mux;
      if (r_idx == RegNowSec) shadow_d = ts.frac;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      run_q       <= 1'b0;
      load_q      <= 1'b0;
      inc_q       <= 32'(INC_RESET);
      set_sec_q   <= '0;
      set_frac_q  <= '0;
      shadow_q    <= '0;
      rdata_q     <= '0;
      cap_valid_q <= '0;
      overrun_q   <= '0;
      for (int unsigned n = 0; n < NUM_CAP; n++) cap_q[n] <= '0;
    end else begin
      run_q       <= run_d;
      load_q      <= load_d;
      inc_q       <= inc_d;
      set_sec_q   <= set_sec_d;
      set_frac_q  <= set_frac_d;
      shadow_q    <= shadow_d;
      rdata_q     <= rdata_d;
      cap_valid_q <= cap_valid_d;
      overrun_q   <= overrun_d;
      cap_q       <= cap_d;
    end
  end

`ifdef NTP_CLIENT_IRQ_EN
  logic irq_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && (w_idx == RegCtrl) && s00_axi.wstrb[0]) begin
        irq_en_q <= s00_axi.wdata[CtrlIrqEn];
      end
      irq_q <= irq_en_q & (|cap_valid_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq_o    = 1'b0;
`endif

  ntp_ts_counter u_counter (
    .clk_i       (s00_axi_aclk),
    .rst_ni      (s00_axi_aresetn),
    .run_i       (run_q),
    .load_i      (load_q),
    .load_sec_i  (set_sec_q),
    .load_frac_i (set_frac_q),
    .inc_i       (inc_q),
    .ts_o        (ts),
    .pps_o       (pps_o)
  );

  assign ntp_sec_o  = ts.sec;
  assign ntp_frac_o = ts.frac;

endmodule

// File: tb/tb_ntp_timestamp_axil.sv
module tb_ntp_timestamp_axil;

  localparam int unsigned NumCap = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NumCap-1:0] cap = '0;
  logic [31:0]       ntp_sec, ntp_frac;
  logic              pps, irq;

  int n_checks = 0;
  int n_errors = 0;

  ntp_timestamp_axil_if #(.AddrWidth(6)) axi ();

  ntp_timestamp_axil #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .NUM_CAP            (NumCap),
    .INC_RESET          (10995)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (axi),
    .cap_i           (cap),
    .ntp_sec_o       (ntp_sec),
    .ntp_frac_o      (ntp_frac),
    .pps_o           (pps),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb = 4'hF,
                           input logic [NumCap-1:0] cap_mask = '0);
    int cnt;
    @(negedge clk);
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.bready  = 1'b1;
    cap         = cap_mask;
    #1;
    cnt = 0;
    while (!axi.awready && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check_eq("aw_handshake", {31'b0, axi.awready & axi.wready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    cap         = '0;
    cnt = 0;
    while (!axi.bvalid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("bvalid", {31'b0, axi.bvalid}, 32'd1);
    @(posedge clk);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
    int cnt;
    @(negedge clk);
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    #1;
    cnt = 0;
    while (!axi.arready && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check_eq("ar_handshake", {31'b0, axi.arready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    axi.arvalid = 1'b0;
    cnt = 0;
    while (!axi.rvalid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("rvalid", {31'b0, axi.rvalid}, 32'd1);
    data = axi.rdata;
    @(posedge clk);
  endtask

  task automatic read_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic pulse_cap(input logic [NumCap-1:0] mask);
    @(negedge clk);
    cap = mask;
    @(negedge clk);
    cap = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, f, exp_irq, exp_ctrl5;
    logic        found;
    int          rolled;

`ifdef NTP_CLIENT_IRQ_EN
    exp_irq   = 32'd1;
    exp_ctrl5 = 32'h5;
`else
    exp_irq   = 32'd0;
    exp_ctrl5 = 32'h1;
`endif

    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // 1: reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_awready", {31'b0, axi.awready}, 32'd0);
    check_eq("rst_bvalid",  {31'b0, axi.bvalid},  32'd0);
    check_eq("rst_arready", {31'b0, axi.arready}, 32'd0);
    check_eq("rst_rvalid",  {31'b0, axi.rvalid},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_sec",  ntp_sec,  32'd0);
    check_eq("rst_frac", ntp_frac, 32'd0);
    check_eq("rst_pps",  {31'b0, pps}, 32'd0);
    check_eq("rst_irq",  {31'b0, irq}, 32'd0);
    for (int a = 0; a < 64; a += 4) begin
      read_check("rst_reg", 6'(a), (a == 4) ? 32'h0000_2AF3 : 32'h0);
    end

    // Writes to RO / unimplemented space are ignored; wstrb honoured.
    axi_write(6'h30, 32'hDEAD_BEEF);
    read_check("unimpl_ignored", 6'h30, 32'h0);
    axi_write(6'h10, 32'hDEAD_BEEF);
    read_check("now_sec_ro", 6'h10, 32'h0);
    axi_write(6'h0C, 32'hAABB_CCDD, 4'b0101);
    read_check("wstrb", 6'h0C, 32'h00BB_00DD);

    // 2: load and run to seconds rollover.
    axi_write(6'h08, 32'hE000_0000);
    axi_write(6'h0C, 32'hFFFF_FF00);
    axi_write(6'h00, 32'h3);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ntp_sec == 32'hE000_0000) found = 1'b1;
    end
    check_eq("load_sec",  ntp_sec,  32'hE000_0000);
    check_eq("load_frac", ntp_frac, 32'hFFFF_FF00);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_eq("pps_timing", {31'b0, pps}, (k == 6) ? 32'd1 : 32'd0);
      if (k == 5) check_eq("frac_k5", ntp_frac, 32'hFFFF_FFD6);
      if (k == 6) begin
        check_eq("sec_roll",  ntp_sec,  32'hE000_0001);
        check_eq("frac_roll", ntp_frac, 32'h0000_0001);
      end
    end
    read_check("ctrl_load_self_clr", 6'h00, 32'h1);

    // 3: capture with frozen time, overrun, W1C.
    axi_write(6'h08, 32'h1234_5678);
    axi_write(6'h0C, 32'h9ABC_DE00);
    axi_write(6'h00, 32'h2);
    pulse_cap(2'b01);
    read_check("status_cap0",  6'h18, 32'h1);
    read_check("cap0_sec",     6'h20, 32'h1234_5678);
    read_check("cap0_frac",    6'h24, 32'h9ABC_DE00);
    axi_write(6'h08, 32'h1111_1111);
    axi_write(6'h00, 32'h2);
    pulse_cap(2'b01);
    read_check("status_ovr",   6'h18, 32'h101);
    read_check("cap0_kept",    6'h20, 32'h1234_5678);
    axi_write(6'h18, 32'h101);
    read_check("status_w1c",   6'h18, 32'h0);

    // 4: capture coinciding with W1C of the same channel.
    pulse_cap(2'b10);
    read_check("cap1_sec",     6'h28, 32'h1111_1111);
    read_check("status_cap1",  6'h18, 32'h2);
    axi_write(6'h08, 32'h2222_2222);
    axi_write(6'h00, 32'h2);
    axi_write(6'h18, 32'h2, 4'hF, 2'b10);
    read_check("status_race",  6'h18, 32'h2);
    read_check("cap1_new",     6'h28, 32'h2222_2222);
    read_check("cap1_frac",    6'h2C, 32'h9ABC_DE00);

    // 5: NOW_FRAC comes from the snapshot taken by NOW_SEC.
    axi_write(6'h08, 32'h5);
    axi_write(6'h0C, 32'hFFFF_FFFF);
    axi_write(6'h00, 32'h2);
    read_check("atomic_sec",   6'h10, 32'h5);
    axi_write(6'h0C, 32'h1111_1100);
    axi_write(6'h00, 32'h2);
    read_check("atomic_shadow", 6'h14, 32'hFFFF_FFFF);
    read_check("atomic_sec2",  6'h10, 32'h5);
    read_check("atomic_frac2", 6'h14, 32'h1111_1100);

    // Response hold with bready / rready low.
    @(negedge clk);
    axi.awaddr = 6'h08; axi.wdata = 32'h5; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bvalid_hold", {31'b0, axi.bvalid}, 32'd1);
      @(negedge clk);
    end
    axi.bready = 1'b1;
    @(negedge clk);
    check_eq("bvalid_drop", {31'b0, axi.bvalid}, 32'd0);
    axi.araddr = 6'h08; axi.arvalid = 1'b1; axi.rready = 1'b0;
    @(negedge clk);
    axi.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("rvalid_hold", {31'b0, axi.rvalid}, 32'd1);
      check_eq("rdata_hold",  axi.rdata, 32'h5);
      @(negedge clk);
    end
    axi.rready = 1'b1;
    @(negedge clk);
    check_eq("rvalid_drop", {31'b0, axi.rvalid}, 32'd0);

    // Pairs across a live seconds rollover: only (5,FFFFFFFF) or (6,0) are coherent.
    axi_write(6'h04, 32'h4);
    axi_write(6'h0C, 32'hFFFF_FFFF);
    axi_write(6'h00, 32'h3);
    rolled = 0;
    for (int i = 0; i < 25; i++) begin
      axi_read(6'h10, s);
      axi_read(6'h14, f);
      if (i == 0) check_eq("scan_first_sec", s, 32'h5);
      check_eq("atomic_pair",
               {31'b0, ((s == 32'h5) && (f == 32'hFFFF_FFFF)) || ((s == 32'h6) && (f == 32'h0))},
               32'd1);
      if (s == 32'h6) rolled++;
    end
    check_eq("scan_last_sec", s, 32'h6);

    // 6: interrupt.
    axi_write(6'h18, 32'h303);
    read_check("status_clear", 6'h18, 32'h0);
    axi_write(6'h00, 32'h5);
    read_check("ctrl_irq_en", 6'h00, exp_ctrl5);
    check_eq("irq_idle", {31'b0, irq}, 32'd0);
    pulse_cap(2'b01);
    check_eq("irq_latency", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check_eq("irq_set", {31'b0, irq}, exp_irq);
    axi_write(6'h18, 32'h1);
    @(negedge clk);
    check_eq("irq_clear", {31'b0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
